ex_stage_seq: RTL and testbench

EX_STAGE_SEQ -- requirements
Module: ex_stage_seq

---
 rtl/ex_pkg.sv | 80 ++++++++
 rtl/ex_mult_seq.sv | 78 +++++++
 rtl/ex_stage_seq.sv | 116 +++++++++++
 tb/tb_ex_stage_seq.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ex_pkg.sv
// Shared definitions for the EX stage: bundle field offsets, ALU/compare encodings, multiplier FSM.
// MULT_RADIX4_EN selects a 2-bit-per-cycle multiplier (16 busy cycles) instead of 1-bit (32).
package ex_pkg;

  localparam int IDEX_W  = 118;
  localparam int EXMEM_W = 75;

  // idex field LSB offsets
  localparam int ID_PC4    = 86;
  localparam int ID_RS     = 81;
  localparam int ID_RT     = 76;
  localparam int ID_RD     = 71;
  localparam int ID_PC8    = 39;
  localparam int ID_REGDST = 38;
  localparam int ID_ALUSRC = 37;
  localparam int ID_MEMREG = 36;
  localparam int ID_REGW   = 35;
  localparam int ID_MEMW   = 34;
  localparam int ID_BEQ    = 33;
  localparam int ID_BNE    = 32;
  localparam int ID_EXTOP  = 31;
  localparam int ID_MULT   = 30;
  localparam int ID_COND   = 29;
  localparam int ID_DEXTOP = 28;
  localparam int ID_JR     = 27;
  localparam int ID_JAL    = 26;
  localparam int ID_LHI    = 25;
  localparam int ID_ALUOP  = 21;
  localparam int ID_CONDOP = 18;
  localparam int ID_DSIZE  = 16;
  localparam int ID_IMM    = 0;

  // exmem field LSB offsets
  localparam int EM_RESULT = 43;
  localparam int EM_STDATA = 11;
  localparam int EM_DEST   = 6;
  localparam int EM_REGW   = 5;
  localparam int EM_MEMREG = 4;
  localparam int EM_MEMW   = 3;
  localparam int EM_DSIZE  = 1;
  localparam int EM_DEXTOP = 0;

  typedef enum logic [3:0] {
    ALU_ADD = 4'b0000,
    ALU_SUB = 4'b0001,
    ALU_AND = 4'b0100,
    ALU_OR  = 4'b0101,
    ALU_XOR = 4'b0110,
    ALU_SLL = 4'b1000,
    ALU_SRL = 4'b1001,
    ALU_SRA = 4'b1010
  } alu_op_e;

  typedef enum logic [2:0] {
    CMP_EQ = 3'b000,
    CMP_NE = 3'b001,
    CMP_LE = 3'b010,
    CMP_LT = 3'b011,
    CMP_GE = 3'b100,
    CMP_GT = 3'b101
  } cond_op_e;

  typedef enum logic [1:0] {
    MS_IDLE,
    MS_BUSY,
    MS_DONE
  } mult_state_e;

`ifdef MULT_RADIX4_EN
  localparam int MULT_BITS = 2;
`else
  localparam int MULT_BITS = 1;
`endif
  localparam int MULT_STEPS = 32 / MULT_BITS;

  function automatic logic [31:0] sext16(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

endpackage

// File: rtl/ex_mult_seq.sv
// Sequential shift-add multiplier: IDLE latches operands, BUSY retires MULT_BITS per cycle, DONE presents product.
// Bit rate follows MULT_RADIX4_EN (see ex_pkg).
module ex_mult_seq
  import ex_pkg::*;
(
  input  logic        gclk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        hold,
  output logic        done,
  output logic [31:0] product
);

  mult_state_e state, state_nxt;
  logic [31:0] mcand, mplier, acc, partial;
  logic [5:0]  cnt;

  always_comb begin
    state_nxt = state;
    hold      = 1'b0;
    done      = 1'b0;
    case (state)
      MS_IDLE: if (start) begin
        hold      = 1'b1;
        state_nxt = MS_BUSY;
      end
      MS_BUSY: begin
        hold = 1'b1;
        if (cnt == 6'(MULT_STEPS - 1)) state_nxt = MS_DONE;
      end
      MS_DONE: begin
        done      = 1'b1;
        state_nxt = MS_IDLE;
      end
      default: state_nxt = MS_IDLE;
    endcase
  end

  always_comb begin
`ifdef MULT_RADIX4_EN
    partial = (mplier[0] ? mcand : 32'h0) + (mplier[1] ? {mcand[30:0], 1'b0} : 32'h0);
`else
    partial = mplier[0] ? mcand : 32'h0;
`endif
  end

  always_ff @(posedge gclk) begin
    if (rst) begin
      state  <= MS_IDLE;
      acc    <= '0;
      cnt    <= '0;
      mcand  <= '0;
      mplier <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        MS_IDLE: if (start) begin
          mcand  <= a;
          mplier <= b;
          acc    <= '0;
          cnt    <= '0;
        end
        MS_BUSY: begin
          acc    <= acc + partial;
          mcand  <= mcand << MULT_BITS;
          mplier <= mplier >> MULT_BITS;
          cnt    <= cnt + 6'd1;
        end
        default: ;
      endcase
    end
  end

  assign product = acc;

endmodule

// File: rtl/ex_stage_seq.sv
// EX pipeline stage: ALU, compare, branch/jr redirect, sequential multiplier, registered EX/MEM bundle.
// Multiplier speed selected by MULT_RADIX4_EN.
module ex_stage_seq
  import ex_pkg::*;
(
  input  logic                 EXclk,
  input  logic                 EXrst,
  input  logic [IDEX_W-1:0]    idex,
  input  logic [31:0]          busA,
  input  logic [31:0]          busB,
  output logic                 EXhold,
  output logic                 redirect,
  output logic [31:0]          redirectPC,
  output logic [EXMEM_W-1:0]   exmem
);

  logic [31:0] pc4, pc8, imm_ext, op_b, alu_res, result, product;
  logic [15:0] imm16;
  logic [4:0]  rt, rd, dest, rs_unused;
  logic [3:0]  alu_op;
  logic [2:0]  cond_op;
  logic [1:0]  dsize;
  logic        reg_dst, alu_src, mem_reg, reg_w, mem_w, beq_f, bne_f, ext_op;
  logic        mult, cond, dextop, jr, jal, lhi, cmp, bubble, mult_hold, mult_done;

  assign pc4       = idex[ID_PC4 +: 32];
  assign rs_unused = idex[ID_RS +: 5];
  assign rt        = idex[ID_RT +: 5];
  assign rd        = idex[ID_RD +: 5];
  assign pc8       = idex[ID_PC8 +: 32];
  assign reg_dst   = idex[ID_REGDST];
  assign alu_src   = idex[ID_ALUSRC];
  assign mem_reg   = idex[ID_MEMREG];
  assign reg_w     = idex[ID_REGW];
  assign mem_w     = idex[ID_MEMW];
  assign beq_f     = idex[ID_BEQ];
  assign bne_f     = idex[ID_BNE];
  assign ext_op    = idex[ID_EXTOP];
  assign mult      = idex[ID_MULT];
  assign cond      = idex[ID_COND];
  assign dextop    = idex[ID_DEXTOP];
  assign jr        = idex[ID_JR];
  assign jal       = idex[ID_JAL];
  assign lhi       = idex[ID_LHI];
  assign alu_op    = idex[ID_ALUOP +: 4];
  assign cond_op   = idex[ID_CONDOP +: 3];
  assign dsize     = idex[ID_DSIZE +: 2];
  assign imm16     = idex[ID_IMM +: 16];

  assign bubble  = (idex == '0);
  assign imm_ext = ext_op ? sext16(imm16) : {16'h0, imm16};
  assign op_b    = alu_src ? imm_ext : busB;

  always_comb begin
    cmp = 1'b0;
    case (cond_op)
      CMP_EQ: cmp = (busA == op_b);
      CMP_NE: cmp = (busA != op_b);
      CMP_LT: cmp = ($signed(busA) <  $signed(op_b));
      CMP_GT: cmp = ($signed(busA) >  $signed(op_b));
      CMP_LE: cmp = ($signed(busA) <= $signed(op_b));
      CMP_GE: cmp = ($signed(busA) >= $signed(op_b));
      default: cmp = 1'b0;
    endcase
  end

  always_comb begin
    alu_res = busA + op_b;
    case (alu_op)
      ALU_SUB: alu_res = busA - op_b;
      ALU_AND: alu_res = busA & op_b;
      ALU_OR:  alu_res = busA | op_b;
      ALU_XOR: alu_res = busA ^ op_b;
      ALU_SLL: alu_res = busA << op_b[4:0];
      ALU_SRL: alu_res = busA >> op_b[4:0];
      ALU_SRA: alu_res = $unsigned($signed(busA) >>> op_b[4:0]);
      default: alu_res = busA + op_b;
    endcase
  end

  always_comb begin
    if (jal)       result = pc8;
    else if (lhi)  result = {imm16, 16'h0};
    else if (cond) result = {31'b0, cmp};
    else if (mult) result = product;
    else           result = alu_res;
  end

  assign dest       = jal ? 5'd31 : (reg_dst ? rd : rt);
  assign redirect   = (beq_f && busA == 32'h0) || (bne_f && busA != 32'h0) || jr;
  assign redirectPC = redirect ? (jr ? busA : pc4 + sext16(imm16)) : 32'h0;

  ex_mult_seq u_mult (
    .gclk    (EXclk),
    .rst     (EXrst),
    .start   (mult),
    .a       (busA),
    .b       (op_b),
    .hold    (mult_hold),
    .done    (mult_done),
    .product (product)
  );

  assign EXhold = mult_hold;

  // A mult that is not yet in DONE sends bubbles downstream
  always_ff @(posedge EXclk) begin
    if (EXrst)
      exmem <= '0;
    else if (bubble || mult_hold || (mult && !mult_done))
      exmem <= '0;
    else
      exmem <= {result, busB, dest, reg_w, mem_reg, mem_w, dsize, dextop};
  end

endmodule

// File: tb/tb_ex_stage_seq.sv
// Randomized self-checking bench for ex_stage_seq against a behavioural model of the EX stage.
module tb_ex_stage_seq;

  typedef struct packed {
    logic [31:0] pc4;
    logic [4:0]  rs, rt, rd;
    logic [31:0] pc8;
    logic reg_dst, alu_src, mem_reg, reg_w, mem_w;
    logic beq, bne, ext_op, mult, cond, dextop;
    logic jr, jal, lhi;
    logic [3:0]  alu_op;
    logic [2:0]  cond_op;
    logic [1:0]  dsize;
    logic [15:0] imm16;
  } idex_t;

`ifdef MULT_RADIX4_EN
  localparam int HOLD_CYCLES = 17;
`else
  localparam int HOLD_CYCLES = 33;
`endif

  logic         EXclk = 1'b0;
  logic         EXrst;
  logic [117:0] idex;
  logic [31:0]  busA, busB;
  logic         EXhold, redirect;
  logic [31:0]  redirectPC;
  logic [74:0]  exmem;

  int n_chk = 0;
  int n_err = 0;

  ex_stage_seq dut (
    .EXclk      (EXclk),
    .EXrst      (EXrst),
    .idex       (idex),
    .busA       (busA),
    .busB       (busB),
    .EXhold     (EXhold),
    .redirect   (redirect),
    .redirectPC (redirectPC),
    .exmem      (exmem)
  );

  always #5 EXclk = ~EXclk;

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [74:0] got, input logic [74:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference EX/MEM contents for one instruction
  function automatic logic [74:0] ref_exmem(input idex_t d, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] imm, opb, r;
    logic [63:0] p;
    logic [4:0]  dst;
    int          sa, sb;
    logic        c;
    if (d == '0) return '0;
    imm = d.ext_op ? {{16{d.imm16[15]}}, d.imm16} : {16'h0, d.imm16};
    opb = d.alu_src ? imm : b;
    sa  = a;
    sb  = opb;
    case (d.cond_op)
      3'd0: c = (sa == sb);
      3'd1: c = (sa != sb);
      3'd3: c = (sa <  sb);
      3'd5: c = (sa >  sb);
      3'd2: c = (sa <= sb);
      3'd4: c = (sa >= sb);
      default: c = 1'b0;
    endcase
    p = {32'h0, a} * {32'h0, opb};
    if (d.jal)       r = d.pc8;
    else if (d.lhi)  r = {d.imm16, 16'h0};
    else if (d.cond) r = {31'b0, c};
    else if (d.mult) r = p[31:0];
    else begin
      case (d.alu_op)
        4'd1:    r = a - opb;
        4'd4:    r = a & opb;
        4'd5:    r = a | opb;
        4'd6:    r = a ^ opb;
        4'd8:    r = a << opb[4:0];
        4'd9:    r = a >> opb[4:0];
        4'd10:   r = sa >>> opb[4:0];
        default: r = a + opb;
      endcase
    end
    dst = d.jal ? 5'd31 : (d.reg_dst ? d.rd : d.rt);
    return {r, b, dst, d.reg_w, d.mem_reg, d.mem_w, d.dsize, d.dextop};
  endfunction

  function automatic logic [31:0] ref_target(input idex_t d, input logic [31:0] a);
    logic taken;
    taken = (d.beq && a == 0) || (d.bne && a != 0) || d.jr;
    if (!taken) return 32'h0;
    if (d.jr) return a;
    return d.pc4 + {{16{d.imm16[15]}}, d.imm16};
  endfunction

  // Single-cycle instruction: check combinational outputs, then the registered bundle
  task automatic apply(input idex_t d, input logic [31:0] a, input logic [31:0] b, output logic [74:0] got);
    logic [74:0] e;
    logic [31:0] t;
    e = ref_exmem(d, a, b);
    t = ref_target(d, a);
    idex = d; busA = a; busB = b;
    #1;
    chk("redirect", redirect, (d.beq && a == 0) || (d.bne && a != 0) || d.jr);
    chk("redirectPC", redirectPC, t);
    chk("hold_idle", EXhold, 0);
    @(posedge EXclk); #1;
    chk("exmem", exmem, e);
    got = exmem;
  endtask

  task automatic run_mult(input idex_t d, input logic [31:0] a, input logic [31:0] b, output logic [74:0] got);
    logic [74:0] e;
    int          holds;
    logic        dirty;
    e = ref_exmem(d, a, b);
    idex = d; busA = a; busB = b;
    #1;
    holds = 0;
    dirty = 1'b0;
    while (EXhold === 1'b1 && holds < 200) begin
      if (holds > 0 && exmem !== '0) dirty = 1'b1;
      holds++;
      @(posedge EXclk); #1;
    end
    chk("mult_hold_cycles", holds, HOLD_CYCLES);
    chk("mult_busy_bubble", dirty, 0);
    @(posedge EXclk); #1;
    got  = exmem;
    idex = '0;
    chk("mult_exmem", got, e);
  endtask

  initial begin
    idex_t       d;
    logic [74:0] got;
    logic [31:0] a, b;

    EXrst = 1'b1; idex = '0; busA = 32'h1234_5678; busB = 32'h9abc_def0;
    repeat (2) @(posedge EXclk);
    #1;
    chk("rst_exmem", exmem, 0);
    chk("rst_hold", EXhold, 0);
    chk("rst_redirect", redirect, 0);
    chk("rst_redirectPC", redirectPC, 0);
    EXrst = 1'b0;

    // add
    d = '0; d.alu_op = 4'd0; d.rd = 5'd3; d.reg_dst = 1'b1; d.reg_w = 1'b1; d.pc4 = 32'h40;
    apply(d, 32'd5, 32'd7, got);
    chk("add_result", got[74:43], 32'd12);
    chk("add_dest", got[10:6], 5'd3);
    chk("add_regw", got[5], 1'b1);

    // beqz taken / not taken
    d = '0; d.beq = 1'b1; d.pc4 = 32'h100; d.imm16 = 16'hFFF0;
    idex = d; busA = 32'h0; busB = 32'h0; #1;
    chk("beqz_taken", redirect, 1'b1);
    chk("beqz_target", redirectPC, 32'hF0);
    busA = 32'h1; #1;
    chk("beqz_not_taken", redirect, 1'b0);
    chk("beqz_target_zero", redirectPC, 32'h0);
    @(posedge EXclk); #1;

    // jal and lhi
    d = '0; d.jal = 1'b1; d.pc8 = 32'h208; d.reg_w = 1'b1;
    apply(d, 32'h0, 32'h0, got);
    chk("jal_dest", got[10:6], 5'd31);
    chk("jal_result", got[74:43], 32'h208);
    d = '0; d.lhi = 1'b1; d.imm16 = 16'hABCD; d.rt = 5'd9;
    apply(d, 32'h0, 32'h0, got);
    chk("lhi_result", got[74:43], 32'hABCD_0000);

    // bubble with live buses
    d = '0;
    apply(d, 32'hdead_beef, 32'hcafe_f00d, got);
    chk("bubble_zero", got, 0);

    // mult directed
    d = '0; d.mult = 1'b1; d.rd = 5'd4; d.reg_dst = 1'b1; d.reg_w = 1'b1;
    run_mult(d, 32'hFFFF_FFFF, 32'd3, got);
    chk("mult_result", got[74:43], 32'hFFFF_FFFD);

    // random single-cycle ops
    for (int i = 0; i < 60; i++) begin
      d = '0;
      d.pc4 = $urandom; d.pc8 = $urandom;
      d.rs = 5'($urandom); d.rt = 5'($urandom); d.rd = 5'($urandom);
      d.reg_dst = 1'($urandom); d.alu_src = 1'($urandom); d.mem_reg = 1'($urandom);
      d.reg_w = 1'($urandom); d.mem_w = 1'($urandom); d.ext_op = 1'($urandom);
      d.dextop = 1'($urandom); d.dsize = 2'($urandom);
      d.beq = ($urandom_range(0, 3) == 0); d.bne = ($urandom_range(0, 3) == 0);
      d.jr  = ($urandom_range(0, 5) == 0);
      d.jal = ($urandom_range(0, 7) == 0); d.lhi = ($urandom_range(0, 7) == 0);
      d.cond = ($urandom_range(0, 4) == 0);
      d.alu_op = 4'($urandom); d.cond_op = 3'($urandom_range(0, 5));
      d.imm16 = 16'($urandom);
      a = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
      b = ($urandom_range(0, 4) == 0) ? a : $urandom;
      apply(d, a, b, got);
    end

    // random mults
    for (int i = 0; i < 4; i++) begin
      d = '0;
      d.mult = 1'b1; d.rt = 5'($urandom); d.rd = 5'($urandom);
      d.reg_dst = 1'($urandom); d.reg_w = 1'b1; d.alu_src = 1'($urandom);
      d.ext_op = 1'($urandom); d.imm16 = 16'($urandom); d.pc4 = $urandom;
      run_mult(d, $urandom, $urandom, got);
    end

    // reset during BUSY cycle 10, then re-issue
    d = '0; d.mult = 1'b1; d.rd = 5'd7; d.reg_dst = 1'b1; d.reg_w = 1'b1;
    idex = d; busA = 32'h0001_0003; busB = 32'h0000_0101; #1;
    repeat (10) @(posedge EXclk);
    #1;
    chk("busy10_hold", EXhold, 1'b1);
    EXrst = 1'b1; idex = '0;
    @(posedge EXclk); #1;
    chk("midrst_hold", EXhold, 0);
    chk("midrst_exmem", exmem, 0);
    chk("midrst_redirect", redirect, 0);
    chk("midrst_redirectPC", redirectPC, 0);
    EXrst = 1'b0;
    @(posedge EXclk); #1;
    chk("postrst_hold", EXhold, 0);
    chk("postrst_exmem", exmem, 0);
    run_mult(d, 32'h0001_0003, 32'h0000_0101, got);
    chk("reissue_result", got[74:43], 32'h0101_0303);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
